stopwatch_ctrl: RTL and testbench

- Control FSM that sequences the 3-digit BCD counter as a stopwatch.
- Turns three push-button levels (start/stop, lap, clear) into counter enable pulses and a synchronous clear pulse.
- Generates the count-rate prescaler and stops at 999 if configured.
- Provides a lap-freeze display mux that drives the 7-segment decoders with either the live or the frozen digits.

---
 rtl/stopwatch_ctrl.sv | 166 ++++++++++++++++
 tb/tb_stopwatch_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/stopwatch_ctrl.sv
// stopwatch_ctrl: sequences a 3-digit BCD counter as a stopwatch.
// Debounced-by-edge button events drive a four-state FSM that issues
// count-step and clear pulses, and a lap register freezes the display.
module stopwatch_ctrl #(
  parameter int N           = 50,
  parameter bit STOP_AT_MAX = 1'b1
) (
  input  logic       clk,
  input  logic       areset,
  input  logic       btn_ss,
  input  logic       btn_lap,
  input  logic       btn_clr,
  input  logic [3:0] cnt_d0,
  input  logic [3:0] cnt_d1,
  input  logic [3:0] cnt_d2,
  input  logic       cnt_maxed,
  output logic       cnt_en,
  output logic       cnt_clr,
  output logic       running,
  output logic       done,
  output logic       lap_hold,
  output logic [3:0] disp0,
  output logic [3:0] disp1,
  output logic [3:0] disp2
);

  localparam int PW = $clog2(N);
  localparam logic [PW-1:0] PRE_LAST = PW'(N - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t        state, state_n;
  logic [PW-1:0] pre, pre_n;
  logic          en_n, clr_n, hold_n;
  logic [3:0]    lap0, lap1, lap2;
  logic [3:0]    lap0_n, lap1_n, lap2_n;

  logic [2:0]    ss_sync, lap_sync, clr_sync;
  logic          ev_ss, ev_lap, ev_clr;
  logic          sel_ss, sel_lap, sel_clr;
  logic          at_max;

  // Three-flop chains: two for metastability, the third to find the rising edge.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      ss_sync  <= 3'b000;
      lap_sync <= 3'b000;
      clr_sync <= 3'b000;
    end else begin
      ss_sync  <= {ss_sync[1:0], btn_ss};
      lap_sync <= {lap_sync[1:0], btn_lap};
      clr_sync <= {clr_sync[1:0], btn_clr};
    end
  end

  assign ev_ss  = ss_sync[1]  & ~ss_sync[2];
  assign ev_lap = lap_sync[1] & ~lap_sync[2];
  assign ev_clr = clr_sync[1] & ~clr_sync[2];

  // Coinciding events resolve as clear over start/stop over lap.
  assign sel_clr = ev_clr;
  assign sel_ss  = ev_ss & ~ev_clr;
  assign sel_lap = ev_lap & ~ev_ss & ~ev_clr;

  assign at_max = STOP_AT_MAX & cnt_maxed;

  // State register.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) state <= IDLE;
    else         state <= state_n;
  end

  // Next state, prescaler step and the next values of the registered outputs.
  always_comb begin
    state_n = state;
    pre_n   = pre;
    en_n    = 1'b0;
    clr_n   = 1'b0;
    hold_n  = lap_hold;
    lap0_n  = lap0;
    lap1_n  = lap1;
    lap2_n  = lap2;

    if (state == RUN) begin
      if (pre == PRE_LAST) begin
        pre_n = '0;
        en_n  = ~at_max;
      end else begin
        pre_n = pre + PW'(1);
      end
    end

    case (state)
      IDLE: begin
        if (sel_ss) begin
          state_n = RUN;
        end else if (sel_clr) begin
          clr_n = 1'b1;
          pre_n = '0;
        end
      end
      RUN: begin
        if (sel_ss)      state_n = PAUSE;
        else if (at_max) state_n = DONE;
        if (sel_lap) begin
          if (lap_hold) begin
            hold_n = 1'b0;
          end else begin
            hold_n = 1'b1;
            lap0_n = cnt_d0;
            lap1_n = cnt_d1;
            lap2_n = cnt_d2;
          end
        end
      end
      PAUSE, DONE: begin
        if (sel_ss && state == PAUSE) state_n = RUN;
        if (sel_lap) hold_n = 1'b0;
        if (sel_clr) begin
          state_n = IDLE;
          clr_n   = 1'b1;
          pre_n   = '0;
          hold_n  = 1'b0;
          lap0_n  = 4'd0;
          lap1_n  = 4'd0;
          lap2_n  = 4'd0;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Prescaler, pulse outputs and lap-freeze registers.
  always_ff @(posedge clk or negedge areset) begin
    if (!areset) begin
      pre      <= '0;
      cnt_en   <= 1'b0;
      cnt_clr  <= 1'b0;
      lap_hold <= 1'b0;
      lap0     <= 4'd0;
      lap1     <= 4'd0;
      lap2     <= 4'd0;
    end else begin
      pre      <= pre_n;
      cnt_en   <= en_n;
      cnt_clr  <= clr_n;
      lap_hold <= hold_n;
      lap0     <= lap0_n;
      lap1     <= lap1_n;
      lap2     <= lap2_n;
    end
  end

  assign running = (state == RUN);
  assign done    = (state == DONE);

  assign disp0 = lap_hold ? lap0 : cnt_d0;
  assign disp1 = lap_hold ? lap1 : cnt_d1;
  assign disp2 = lap_hold ? lap2 : cnt_d2;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// tb_stopwatch_ctrl: drives two controllers (halt-at-999 and wrap) with
// shared buttons, each attached to a behavioural BCD counter, and checks
// them every cycle against a mode/phase model plus directed literal checks.
module tb_stopwatch_ctrl;

  localparam int NP = 4;

  typedef enum int {M_IDLE, M_RUN, M_PAUSE, M_DONE} mmode_t;

  logic clk = 1'b0;
  logic areset = 1'b0;
  logic btn_ss = 1'b0, btn_lap = 1'b0, btn_clr = 1'b0;

  int   cval [2] = '{0, 0};
  bit   preset_req = 1'b0;
  int   preset_val = 0;
  bit   en_seen [2] = '{1'b0, 1'b0};
  bit   clr_seen [2] = '{1'b0, 1'b0};

  logic [3:0] d0 [2], d1 [2], d2 [2];
  logic       maxed [2];
  logic       en_o [2], clr_o [2], run_o [2], done_o [2], hold_o [2];
  logic [3:0] q0 [2], q1 [2], q2 [2];

  int  n_tests = 0;
  int  n_fail  = 0;
  bit  chk_on  = 1'b0;

  mmode_t m_mode [2] = '{M_IDLE, M_IDLE};
  int     m_phase [2] = '{0, 0};
  bit     m_en [2] = '{1'b0, 1'b0};
  bit     m_clr [2] = '{1'b0, 1'b0};
  bit     m_hold [2] = '{1'b0, 1'b0};
  int     m_lap [2] = '{0, 0};
  bit     stop_cfg [2] = '{1'b1, 1'b0};
  bit     b_prev [3] = '{0, 0, 0};
  bit     b_rise0 [3] = '{0, 0, 0};
  bit     b_rise1 [3] = '{0, 0, 0};

  always #5 clk = ~clk;

  for (genvar g = 0; g < 2; g++) begin : g_digits
    assign d0[g]    = 4'(cval[g] % 10);
    assign d1[g]    = 4'((cval[g] / 10) % 10);
    assign d2[g]    = 4'(cval[g] / 100);
    assign maxed[g] = (cval[g] == 999);
  end

  stopwatch_ctrl #(.N(NP), .STOP_AT_MAX(1'b1)) dut0 (
    .clk(clk), .areset(areset), .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .cnt_d0(d0[0]), .cnt_d1(d1[0]), .cnt_d2(d2[0]), .cnt_maxed(maxed[0]),
    .cnt_en(en_o[0]), .cnt_clr(clr_o[0]), .running(run_o[0]), .done(done_o[0]),
    .lap_hold(hold_o[0]), .disp0(q0[0]), .disp1(q1[0]), .disp2(q2[0])
  );

  stopwatch_ctrl #(.N(NP), .STOP_AT_MAX(1'b0)) dut1 (
    .clk(clk), .areset(areset), .btn_ss(btn_ss), .btn_lap(btn_lap), .btn_clr(btn_clr),
    .cnt_d0(d0[1]), .cnt_d1(d1[1]), .cnt_d2(d2[1]), .cnt_maxed(maxed[1]),
    .cnt_en(en_o[1]), .cnt_clr(clr_o[1]), .running(run_o[1]), .done(done_o[1]),
    .lap_hold(hold_o[1]), .disp0(q0[1]), .disp1(q1[1]), .disp2(q2[1])
  );

  task automatic checkOutput(input string name, input int actual, input int expected);
    n_tests++;
    if (actual != expected) begin
      n_fail++;
      if (n_fail <= 40)
        $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, actual, expected);
    end
  endtask

  task automatic applyStimulus(input bit ss, input bit lap, input bit clr, input int hold);
    btn_ss  = ss;
    btn_lap = lap;
    btn_clr = clr;
    repeat (hold) @(negedge clk);
    btn_ss  = 1'b0;
    btn_lap = 1'b0;
    btn_clr = 1'b0;
  endtask

  task automatic countPulses(input bit use_clr, input int cycles, output int c0, output int c1);
    c0 = 0;
    c1 = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (use_clr ? clr_o[0] : en_o[0]) c0++;
      if (use_clr ? clr_o[1] : en_o[1]) c1++;
    end
  endtask

  task automatic presetCounter(input int v);
    preset_val = v;
    preset_req = 1'b1;
    @(negedge clk);
    preset_req = 1'b0;
  endtask

  // External BCD counter: preset, then clear, then step, from pulses seen last cycle.
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (preset_req)       cval[i] <= preset_val;
      else if (clr_seen[i]) cval[i] <= 0;
      else if (en_seen[i])  cval[i] <= (cval[i] + 1) % 1000;
    end
  end

  // Capture the controller pulses mid-cycle for the counter to act on.
  always @(negedge clk) begin
    for (int i = 0; i < 2; i++) begin
      en_seen[i]  = en_o[i];
      clr_seen[i] = clr_o[i];
    end
  end

  // Reference model: a press is acted on two edges after its rise is sampled.
  always @(posedge clk or negedge areset) begin
    if (!areset) begin
      for (int b = 0; b < 3; b++) begin
        b_prev[b] = 1'b0; b_rise0[b] = 1'b0; b_rise1[b] = 1'b0;
      end
      for (int i = 0; i < 2; i++) begin
        m_mode[i] = M_IDLE; m_phase[i] = 0; m_en[i] = 1'b0;
        m_clr[i] = 1'b0; m_hold[i] = 1'b0; m_lap[i] = 0;
      end
    end else begin
      bit now_b [3];
      bit act [3];
      bit e_ss, e_lap, e_clr, hit_max;
      now_b[0] = btn_ss; now_b[1] = btn_lap; now_b[2] = btn_clr;
      for (int b = 0; b < 3; b++) begin
        act[b]     = b_rise1[b];
        b_rise1[b] = b_rise0[b];
        b_rise0[b] = now_b[b] && !b_prev[b];
        b_prev[b]  = now_b[b];
      end
      e_clr = act[2];
      e_ss  = act[0] && !e_clr;
      e_lap = act[1] && !act[0] && !e_clr;
      for (int i = 0; i < 2; i++) begin
        hit_max  = stop_cfg[i] && (cval[i] == 999);
        m_en[i]  = 1'b0;
        m_clr[i] = 1'b0;
        if (m_mode[i] == M_RUN) begin
          m_phase[i] = (m_phase[i] + 1) % NP;
          if (m_phase[i] == 0 && !hit_max) m_en[i] = 1'b1;
        end
        case (m_mode[i])
          M_IDLE: begin
            if (e_ss) m_mode[i] = M_RUN;
            else if (e_clr) m_clr[i] = 1'b1;
          end
          M_RUN: begin
            if (e_ss) m_mode[i] = M_PAUSE;
            else if (hit_max) m_mode[i] = M_DONE;
            if (e_lap) begin
              if (m_hold[i]) m_hold[i] = 1'b0;
              else begin m_hold[i] = 1'b1; m_lap[i] = cval[i]; end
            end
          end
          default: begin
            if (e_ss && m_mode[i] == M_PAUSE) m_mode[i] = M_RUN;
            if (e_lap) m_hold[i] = 1'b0;
            if (e_clr) begin
              m_mode[i] = M_IDLE; m_clr[i] = 1'b1; m_phase[i] = 0;
              m_hold[i] = 1'b0; m_lap[i] = 0;
            end
          end
        endcase
      end
    end
  end

  // Every-cycle comparison of both controllers against the model.
  always @(negedge clk) begin
    int shown;
    if (chk_on) begin
      for (int i = 0; i < 2; i++) begin
        shown = m_hold[i] ? m_lap[i] : cval[i];
        checkOutput($sformatf("i%0d.cnt_en", i),   int'(en_o[i]),   int'(m_en[i]));
        checkOutput($sformatf("i%0d.cnt_clr", i),  int'(clr_o[i]),  int'(m_clr[i]));
        checkOutput($sformatf("i%0d.running", i),  int'(run_o[i]),  int'(m_mode[i] == M_RUN));
        checkOutput($sformatf("i%0d.done", i),     int'(done_o[i]), int'(m_mode[i] == M_DONE));
        checkOutput($sformatf("i%0d.lap_hold", i), int'(hold_o[i]), int'(m_hold[i]));
        checkOutput($sformatf("i%0d.disp0", i),    int'(q0[i]),     shown % 10);
        checkOutput($sformatf("i%0d.disp1", i),    int'(q1[i]),     (shown / 10) % 10);
        checkOutput($sformatf("i%0d.disp2", i),    int'(q2[i]),     shown / 100);
      end
    end
  end

  // Runaway guard.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  // Directed scenario sequence.
  initial begin
    int c0, c1, c, tr, te;
    @(negedge clk);
    chk_on = 1'b1;

    presetCounter(457);
    checkOutput("rst.running", int'(run_o[0]), 0);
    checkOutput("rst.cnt_en", int'(en_o[0]), 0);
    checkOutput("rst.lap_hold", int'(hold_o[0]), 0);
    checkOutput("rst.disp0", int'(q0[0]), 7);
    checkOutput("rst.disp2", int'(q2[0]), 4);

    areset = 1'b1;
    countPulses(1'b0, 50, c0, c1);
    checkOutput("idle.en_count", c0, 0);
    checkOutput("idle.running", int'(run_o[0]), 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    c = 0;
    while (!run_o[0] && c < 20) begin @(negedge clk); c++; end
    checkOutput("ss.latency", c, 2);
    countPulses(1'b0, 40, c0, c1);
    checkOutput("run.en_count_40", c0, 10);

    c = 0;
    do begin @(negedge clk); c++; end while (!en_o[0] && c < 10);
    checkOutput("run.en_seen", int'(en_o[0]), 1);
    repeat (3) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    repeat (2) @(negedge clk);
    checkOutput("pause.running", int'(run_o[0]), 0);
    countPulses(1'b0, 20, c0, c1);
    checkOutput("pause.en_count", c0, 0);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    tr = -1; te = -1;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      if (tr < 0 && run_o[0]) tr = k;
      if (te < 0 && en_o[0]) te = k;
    end
    checkOutput("resume.latency", tr, 2);
    checkOutput("resume.first_en_gap", te - tr, 2);

    c = 0;
    do begin @(negedge clk); c++; end while (!en_o[0] && c < 10);
    preset_val = 123;
    preset_req = 1'b1;
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    preset_req = 1'b0;
    repeat (6) @(negedge clk);
    checkOutput("lap.hold", int'(hold_o[0]), 1);
    checkOutput("lap.disp0", int'(q0[0]), 3);
    checkOutput("lap.disp1", int'(q1[0]), 2);
    checkOutput("lap.disp2", int'(q2[0]), 1);
    checkOutput("lap.live_moved", int'(cval[0] > 123), 1);
    repeat (6) @(negedge clk);
    applyStimulus(1'b0, 1'b1, 1'b0, 1);
    repeat (4) @(negedge clk);
    checkOutput("lap2.hold", int'(hold_o[0]), 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    repeat (4) @(negedge clk);
    checkOutput("max.paused", int'(run_o[0]), 0);
    presetCounter(998);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    c = 0;
    while (!done_o[0] && c < 30) begin @(negedge clk); c++; end
    checkOutput("max.done", int'(done_o[0]), 1);
    checkOutput("max.running", int'(run_o[0]), 0);
    countPulses(1'b0, 20, c0, c1);
    checkOutput("max.en_after_done", c0, 0);
    checkOutput("wrap.running", int'(run_o[1]), 1);
    checkOutput("wrap.done", int'(done_o[1]), 0);
    checkOutput("wrap.value_low", int'(cval[1] <= 10), 1);

    applyStimulus(1'b0, 1'b0, 1'b1, 1);
    countPulses(1'b1, 8, c0, c1);
    checkOutput("done_clr.pulses", c0, 1);
    checkOutput("done_clr.done", int'(done_o[0]), 0);
    checkOutput("done_clr.count_zero", cval[0], 0);
    checkOutput("done_clr.wrap_unaffected", c1, 0);

    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    repeat (10) @(negedge clk);
    checkOutput("midrst.pre_running", int'(run_o[0]), 1);
    #3 areset = 1'b0;
    #1;
    checkOutput("midrst.running", int'(run_o[0]), 0);
    checkOutput("midrst.cnt_en", int'(en_o[0]), 0);
    checkOutput("midrst.lap_hold", int'(hold_o[0]), 0);
    repeat (2) @(negedge clk);
    areset = 1'b1;

    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    repeat (8) @(negedge clk);
    applyStimulus(1'b1, 1'b0, 1'b0, 1);
    repeat (8) @(negedge clk);
    checkOutput("both.paused", int'(run_o[0] | run_o[1]), 0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1);
    countPulses(1'b1, 8, c0, c1);
    checkOutput("ssclr.i0_clr", c0, 1);
    checkOutput("ssclr.i1_clr", c1, 1);
    checkOutput("ssclr.running", int'(run_o[0] | run_o[1]), 0);
    repeat (4) @(negedge clk);

    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
